fp_cond_branch_unit: RTL and testbench

Consumer end of the single-precision FP compare path: holds the architectural FP condition flag (FCC), pipelines compare results from EX through MEM into FCC, and resolves `bc1t`/`bc1f` branches in ID. Detects the compare→branch hazard, forwards from the MEM-stage copy, stalls ID when the compare is still in EX, and produces the branch target and IF flush. Sits between the EX-stage FP compare and the ID-stage branch/hazard logic.

---
 rtl/fp_cond_branch_unit_if.sv | 31 +++
 rtl/fp_cond_branch_unit.sv | 61 ++++++
 tb/tb_fp_cond_branch_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fp_cond_branch_unit_if.sv
// Signal bundle between the FP compare/branch pipeline and the FCC/branch-resolution unit.
interface fp_cond_branch_unit_if #(
    parameter int unsigned STALL_CNT_W = 16
);
    logic                   stall_in;
    logic                   ex_cmp_valid;
    logic                   ex_fp_cond;
    logic                   ex_kill;
    logic                   id_bc1_valid;
    logic                   id_bc1_tf;
    logic [31:0]            id_pc_plus4;
    logic [15:0]            id_offset;
    logic                   fcc;
    logic                   stall_id;
    logic                   branch_taken;
    logic [31:0]            branch_target;
    logic                   flush_if;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output stall_in, ex_cmp_valid, ex_fp_cond, ex_kill,
               id_bc1_valid, id_bc1_tf, id_pc_plus4, id_offset,
        input  fcc, stall_id, branch_taken, branch_target, flush_if, stall_count
    );

    modport slave (
        input  stall_in, ex_cmp_valid, ex_fp_cond, ex_kill,
               id_bc1_valid, id_bc1_tf, id_pc_plus4, id_offset,
        output fcc, stall_id, branch_taken, branch_target, flush_if, stall_count
    );
endinterface

// File: rtl/fp_cond_branch_unit.sv
// Holds the FP condition flag, pipelines compare results EX->MEM->FCC and
// resolves bc1t/bc1f in ID with MEM-stage forwarding and a one-cycle EX hazard stall.
module fp_cond_branch_unit #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    fp_cond_branch_unit_if.slave  bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned OFF_W  = 16;

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

    logic                   r_fcc;
    logic                   r_mem_cmp_valid;
    logic                   r_mem_fp_cond;
    logic [STALL_CNT_W-1:0] r_stall_count;

    logic              w_ex_live;
    logic              w_stall_id;
    logic              w_cond;
    logic              w_taken;
    logic [ADDR_W-1:0] w_offset_sext;

    // A killed EX compare neither stalls the branch nor reaches MEM.
    assign w_ex_live  = bus.ex_cmp_valid & ~bus.ex_kill;
    assign w_stall_id = bus.id_bc1_valid & w_ex_live & ~reset;

    // MEM holds the newest in-flight result, so it wins over the architectural flag.
    assign w_cond  = r_mem_cmp_valid ? r_mem_fp_cond : r_fcc;
    assign w_taken = bus.id_bc1_valid & ~w_stall_id & ~bus.stall_in & ~reset
                   & (w_cond == bus.id_bc1_tf);

    assign w_offset_sext = {{(ADDR_W - OFF_W - 2){bus.id_offset[OFF_W-1]}}, bus.id_offset, 2'b00};

    assign bus.branch_target = bus.id_pc_plus4 + w_offset_sext;
    assign bus.stall_id      = w_stall_id;
    assign bus.branch_taken  = w_taken;
    assign bus.flush_if      = w_taken;
    assign bus.fcc           = r_fcc;
    assign bus.stall_count   = r_stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fcc           <= 1'b0;
            r_mem_cmp_valid <= 1'b0;
            r_mem_fp_cond   <= 1'b0;
            r_stall_count   <= '0;
        end else if (!bus.stall_in) begin
            r_mem_cmp_valid <= w_ex_live;
            r_mem_fp_cond   <= bus.ex_fp_cond;
            if (r_mem_cmp_valid) begin
                r_fcc <= r_mem_fp_cond;
            end
            if (w_stall_id && (r_stall_count != CNT_MAX)) begin
                r_stall_count <= r_stall_count + STALL_CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fp_cond_branch_unit.sv
// Directed and randomized checks of fp_cond_branch_unit against a cycle-level behavioural model.
module tb_fp_cond_branch_unit;
    logic clk;
    logic reset;

    fp_cond_branch_unit_if #(.STALL_CNT_W(16)) bus ();

    fp_cond_branch_unit #(.STALL_CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks;
    int errors;

    // Behavioural model state: architectural flag, MEM-stage slot, stall count.
    bit m_fcc;
    bit m_mem_v;
    bit m_mem_c;
    int m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit bc1, input bit tf, input bit cv, input bit cond,
                          input bit kill, input bit sin);
        bus.id_bc1_valid = bc1;
        bus.id_bc1_tf    = tf;
        bus.ex_cmp_valid = cv;
        bus.ex_fp_cond   = cond;
        bus.ex_kill      = kill;
        bus.stall_in     = sin;
    endtask

    // One cycle: check every output mid-cycle against the model, then advance the model at the edge.
    task automatic step();
        bit  e_stall;
        bit  e_cond;
        bit  e_taken;
        int  off;
        logic [31:0] e_tgt;
        @(negedge clk);
        e_stall = bus.id_bc1_valid && bus.ex_cmp_valid && !bus.ex_kill && !reset;
        e_cond  = m_mem_v ? m_mem_c : m_fcc;
        e_taken = bus.id_bc1_valid && !e_stall && !bus.stall_in && !reset
                  && (e_cond == bus.id_bc1_tf);
        off     = int'($signed(bus.id_offset));
        e_tgt   = bus.id_pc_plus4 + 32'(off * 4);
        chk("stall_id",      32'(bus.stall_id),     32'(e_stall));
        chk("branch_taken",  32'(bus.branch_taken), 32'(e_taken));
        chk("flush_if",      32'(bus.flush_if),     32'(e_taken));
        chk("branch_target", bus.branch_target,     e_tgt);
        chk("fcc",           32'(bus.fcc),          32'(m_fcc));
        chk("stall_count",   32'(bus.stall_count),  32'(m_cnt));
        @(posedge clk);
        if (reset) begin
            m_fcc = 0; m_mem_v = 0; m_mem_c = 0; m_cnt = 0;
        end else if (!bus.stall_in) begin
            if (e_stall && m_cnt < 65535) m_cnt++;
            if (m_mem_v) m_fcc = m_mem_c;
            m_mem_v = bus.ex_cmp_valid && !bus.ex_kill;
            m_mem_c = bus.ex_fp_cond;
        end
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_fcc = 0; m_mem_v = 0; m_mem_c = 0; m_cnt = 0;
        reset = 1'b1;
        bus.id_pc_plus4 = 32'h0000_1000;
        bus.id_offset   = 16'h0004;
        set_in(0, 0, 1, 1, 0, 0);
        @(posedge clk);
        #1;

        // Reset with a compare sitting in EX: nothing may be captured.
        set_in(1, 1, 1, 1, 0, 0);
        step();
        step();
        chk("reset_fcc", 32'(bus.fcc), 32'd0);
        chk("reset_cnt", 32'(bus.stall_count), 32'd0);
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("post_reset_fcc", 32'(bus.fcc), 32'd0);

        // Commit latency: EX at t, fcc visible at t+2, bc1t taken at t+3.
        set_in(0, 0, 1, 1, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        chk("lat_t1_fcc", 32'(bus.fcc), 32'd0);
        step();
        chk("lat_t2_fcc", 32'(bus.fcc), 32'd1);
        step();
        bus.id_pc_plus4 = 32'h0040_0010;
        bus.id_offset   = 16'hFFFC;
        set_in(1, 1, 0, 0, 0, 0);
        #1;
        chk("lat_taken",  32'(bus.branch_taken), 32'd1);
        chk("lat_target", bus.branch_target, 32'h0040_0000);
        step();

        // Hazard: bc1f behind a compare producing 1 stalls once, then falls through.
        set_in(1, 0, 1, 1, 0, 0);
        #1;
        chk("haz_stall", 32'(bus.stall_id), 32'd1);
        step();
        set_in(1, 0, 0, 0, 0, 0);
        #1;
        chk("haz_t1_stall", 32'(bus.stall_id), 32'd0);
        chk("haz_t1_taken", 32'(bus.branch_taken), 32'd0);
        chk("haz_t1_cnt",   32'(bus.stall_count), 32'd1);
        step();

        // Back-to-back compares: MEM copy (0) overrides fcc (1).
        set_in(0, 0, 1, 1, 0, 0);
        step();
        set_in(0, 0, 1, 0, 0, 0);
        step();
        set_in(1, 1, 0, 0, 0, 0);
        #1;
        chk("b2b_taken", 32'(bus.branch_taken), 32'd0);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        chk("b2b_fcc", 32'(bus.fcc), 32'd0);
        step();

        // Killed compare: no stall, no effect on fcc.
        set_in(1, 1, 1, 1, 1, 0);
        #1;
        chk("kill_stall", 32'(bus.stall_id), 32'd0);
        chk("kill_taken", 32'(bus.branch_taken), 32'd0);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("kill_fcc", 32'(bus.fcc), 32'd0);

        // Freeze with a compare in MEM: fcc holds until release.
        set_in(0, 0, 1, 1, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 1, 0, 0, 1);
            step();
            chk("frz_fcc", 32'(bus.fcc), 32'd0);
        end
        set_in(0, 0, 0, 0, 0, 0);
        step();
        chk("frz_rel_fcc", 32'(bus.fcc), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            bus.id_pc_plus4 = $urandom;
            bus.id_offset   = 16'($urandom);
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
            step();
        end

        // Saturation: hold the hazard for 2^16+5 cycles.
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        set_in(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 65536 + 5; i++) step();
        chk("sat_cnt", 32'(bus.stall_count), 32'h0000_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
